mem_bus_arbiter: RTL

- Shares one SRAM-like memory bus between the IF-stage instruction-fetch port and the MEM-stage data port.
- Uses a req / addr_ok / data_ok handshake on both sides.
- Grants at most one outstanding transaction at a time.
- Data-side priority, with a bounded-streak rule so instruction fetch is never starved.

---
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between the IF fetch port and the MEM data port.
// One transaction in flight at a time; data wins ties, with a bounded streak.
module mem_bus_arbiter #(
  parameter int DATA_STREAK_MAX = 4,
  parameter int STREAK_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic                OWN_INST   = 1'b0;
  localparam logic                OWN_DATA   = 1'b1;
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(DATA_STREAK_MAX);

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic                r_wr;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;

  logic w_idle;
  logic w_grant_d;
  logic w_grant_i;
  logic w_streak_full;

  // Gate with resetn so addr_ok stays low combinationally while reset is held.
  assign w_idle        = (r_state == S_IDLE) & resetn;
  assign w_streak_full = (r_streak == STREAK_SAT);
  assign w_grant_d     = w_idle & data_req & ~(inst_req & w_streak_full);
  assign w_grant_i     = w_idle & inst_req & ~w_grant_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner  <= OWN_INST;
      r_streak <= '0;
      r_wr     <= 1'b0;
      r_wstrb  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_grant_d) begin
      r_owner <= OWN_DATA;
      r_wr    <= data_wr;
      r_wstrb <= data_wstrb;
      r_addr  <= data_addr;
      r_wdata <= data_wdata;
      // Streak only counts data grants that actually made fetch wait.
      if (!inst_req)          r_streak <= '0;
      else if (!w_streak_full) r_streak <= r_streak + STREAK_W'(1);
    end else if (w_grant_i) begin
      r_owner  <= OWN_INST;
      r_wr     <= 1'b0;
      r_wstrb  <= '0;
      r_addr   <= inst_addr;
      r_wdata  <= '0;
      r_streak <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    inst_addr_ok = w_grant_i;
    data_addr_ok = w_grant_d;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    bus_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d | w_grant_i) w_next = S_REQ;
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_addr_ok) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus_data_ok) begin
          w_next = S_IDLE;
          if (r_owner == OWN_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = bus_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = bus_rdata;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latched fields are zero after reset, so the bus outputs also read zero then.
  assign bus_wr    = r_wr;
  assign bus_wstrb = r_wstrb;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule
